// File: rtl/iiitb_rv32i_pkg.sv
// Shared definitions for the memory arbiter: default widths, fairness bound
// and the read-owner state encoding.
package iiitb_rv32i_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int FAIR_N_DEF = 3;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2
  } rd_own_e;

  // Width needed to count 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/iiitb_mem_arb_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the
// single-port memory. slave = arbiter side, master = requesters + memory.
interface iiitb_mem_arb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              stall_if;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, stall_if,
           ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, stall_if,
           ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/iiitb_arb_fair.sv
// Grant logic: load/store wins by default, but after FAIR_N consecutive
// load/store wins over a waiting fetch, the fetch is granted once.
module iiitb_arb_fair
  import iiitb_rv32i_pkg::*;
#(
  parameter int FAIR_N = FAIR_N_DEF,
  parameter int CNT_W  = cnt_w(FAIR_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic             ls_req,
  output logic             if_gnt,
  output logic             ls_gnt,
  output logic [CNT_W-1:0] starve_cnt
);

  logic starved;

  assign starved = if_req && (starve_cnt == CNT_W'(FAIR_N));
  assign ls_gnt  = ls_req && !starved;
  assign if_gnt  = if_req && !ls_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (if_gnt)
      starve_cnt <= '0;
    else if (ls_gnt && if_req && starve_cnt != CNT_W'(FAIR_N))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/iiitb_mem_arb.sv
// Fetch vs load/store arbiter for a shared single-port synchronous memory.
// Grants are combinational; read data is routed back by a read-owner FSM.
module iiitb_mem_arb
  import iiitb_rv32i_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FAIR_N = FAIR_N_DEF
) (
  input logic            clk,
  input logic            RN,
  iiitb_mem_arb_if.slave bus
);

  localparam int CNT_W = cnt_w(FAIR_N);

  logic              if_req_v, ls_req_v;
  logic              if_win, ls_win, any_win;
  logic [CNT_W-1:0]  starve_cnt;
  rd_own_e           state_q, state_d;
  logic              if_rv, ls_rv;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q;

  // Requests are masked while RN is low so every output reads 0 during reset.
  assign if_req_v = bus.if_req && RN;
  assign ls_req_v = bus.ls_req && RN;

  iiitb_arb_fair #(.FAIR_N(FAIR_N), .CNT_W(CNT_W)) u_fair (
    .clk        (clk),
    .rst_n      (RN),
    .if_req     (if_req_v),
    .ls_req     (ls_req_v),
    .if_gnt     (if_win),
    .ls_gnt     (ls_win),
    .starve_cnt (starve_cnt)
  );

  assign any_win = if_win || ls_win;

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) state_q <= NONE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = NONE;
    if_rv   = 1'b0;
    ls_rv   = 1'b0;
    if (if_win)                    state_d = IF_RD;
    else if (ls_win && !bus.ls_we) state_d = LS_RD;
    case (state_q)
      IF_RD:   if_rv = 1'b1;
      LS_RD:   ls_rv = 1'b1;
      default: ;
    endcase
  end

  // Address/data hold their last issued value across idle cycles.
  always_comb begin
    addr_d = addr_q;
    if (if_win)      addr_d = bus.if_addr;
    else if (ls_win) addr_d = bus.ls_addr;
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (any_win) begin
      addr_q  <= addr_d;
      wdata_q <= bus.ls_wdata;
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.ls_gnt    = ls_win;
  assign bus.stall_if  = if_req_v && !if_win;
  assign bus.mem_en    = any_win;
  assign bus.mem_we    = ls_win && bus.ls_we;
  assign bus.mem_addr  = addr_d;
  assign bus.mem_wdata = any_win ? bus.ls_wdata : wdata_q;
  assign bus.if_rvalid = if_rv;
  assign bus.ls_rvalid = ls_rv;
  assign bus.if_rdata  = if_rv ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = ls_rv ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_iiitb_mem_arb.sv
// Directed bench for iiitb_mem_arb: a behavioural memory sits on the mem_*
// side, and expected read data is queued at grant and popped at rvalid.
module tb_iiitb_mem_arb;

  logic clk = 1'b0;
  logic RN  = 1'b0;
  int   ncmp = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  iiitb_mem_arb_if #(.ADDR_W(5), .DATA_W(32)) b ();

  iiitb_mem_arb #(.ADDR_W(5), .DATA_W(32), .FAIR_N(3)) dut (
    .clk (clk),
    .RN  (RN),
    .bus (b)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h0232_8400 : (32'hA500_0000 ^ (i * 32'h0101_0101));
  endfunction

  // Memory under the arbiter; loads its contents on the first edge (in reset).
  logic [31:0] mem [32];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (b.mem_en) begin
      if (b.mem_we) mem[b.mem_addr] <= b.mem_wdata;
      else          b.mem_rdata     <= mem[b.mem_addr];
    end
  end

  logic [31:0] ref_mem [32];
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  logic [4:0]  last_addr;
  logic [31:0] last_wd;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({b.if_gnt, b.ls_gnt, b.if_rvalid, b.ls_rvalid,
                            b.mem_en, b.mem_we, b.stall_if}), 32'd0);
    chk({tag, "_if_rdata"},  b.if_rdata, 32'd0);
    chk({tag, "_ls_rdata"},  b.ls_rdata, 32'd0);
    chk({tag, "_mem_addr"},  32'(b.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, b.mem_wdata, 32'd0);
  endtask

  // One clock of stimulus: drive at negedge, check grants before the edge,
  // check read return after the edge.
  task automatic step(input logic ifr, input logic [4:0] ifa,
                      input logic lsr, input logic we, input logic [4:0] lsa,
                      input logic [31:0] wd, input logic eg_if, input logic eg_ls);
    logic exp_ifv, exp_lsv;
    @(negedge clk);
    b.if_req = ifr; b.if_addr = ifa;
    b.ls_req = lsr; b.ls_we = we; b.ls_addr = lsa; b.ls_wdata = wd;
    #1;
    chk("if_gnt",   32'(b.if_gnt),   32'(eg_if));
    chk("ls_gnt",   32'(b.ls_gnt),   32'(eg_ls));
    chk("stall_if", 32'(b.stall_if), 32'(ifr && !eg_if));
    chk("mem_en",   32'(b.mem_en),   32'(eg_if || eg_ls));
    if (eg_if) begin
      chk("mem_addr_if", 32'(b.mem_addr), 32'(ifa));
      chk("mem_we_if",   32'(b.mem_we), 32'd0);
      if_q.push_back(ref_mem[ifa]);
      last_addr = ifa;
    end else if (eg_ls) begin
      chk("mem_addr_ls", 32'(b.mem_addr), 32'(lsa));
      chk("mem_we_ls",   32'(b.mem_we), 32'(we));
      if (we) ref_mem[lsa] = wd;
      else    ls_q.push_back(ref_mem[lsa]);
      last_addr = lsa;
    end else begin
      chk("mem_addr_hold",  32'(b.mem_addr), 32'(last_addr));
      chk("mem_wdata_hold", b.mem_wdata, last_wd);
    end
    if (eg_if || eg_ls) begin
      chk("mem_wdata", b.mem_wdata, wd);
      last_wd = wd;
    end
    exp_ifv = eg_if;
    exp_lsv = eg_ls && !we;
    @(posedge clk); #1;
    chk("if_rvalid", 32'(b.if_rvalid), 32'(exp_ifv));
    chk("ls_rvalid", 32'(b.ls_rvalid), 32'(exp_lsv));
    if (b.if_rvalid) begin
      if (if_q.size() > 0) chk("if_rdata", b.if_rdata, if_q.pop_front());
      else chk("if_q_underflow", 32'd1, 32'd0);
    end
    if (b.ls_rvalid) begin
      if (ls_q.size() > 0) chk("ls_rdata", b.ls_rdata, ls_q.pop_front());
      else chk("ls_q_underflow", 32'd1, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    last_addr = '0; last_wd = '0;
    // Requests held high during reset must not leak to any output.
    b.if_req = 1'b1; b.if_addr = 5'd4; b.ls_req = 1'b1; b.ls_we = 1'b1;
    b.ls_addr = 5'd9; b.ls_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    chk("reset_cnt", 32'(dut.u_fair.starve_cnt), 32'd0);
    @(negedge clk);
    b.if_req = 1'b0; b.ls_req = 1'b0; b.ls_we = 1'b0;
    RN = 1'b1;

    // Fetch only, then an idle cycle (address/data hold).
    step(1, 5'd4, 0, 0, 5'd0, 32'h0, 1, 0);
    step(0, 5'd0, 0, 0, 5'd0, 32'h5555_AAAA, 0, 0);

    // Store then load of the same word.
    step(0, 5'd0, 1, 1, 5'd3, 32'hDEAD_BEEF, 0, 1);
    step(0, 5'd0, 1, 0, 5'd3, 32'h0, 0, 1);
    chk("mem3_written", mem[3], 32'hDEAD_BEEF);

    // Simultaneous requests with an empty starvation count.
    step(1, 5'd7, 1, 0, 5'd9, 32'h0, 0, 1);
    chk("starve_cnt_1", 32'(dut.u_fair.starve_cnt), 32'd1);
    step(1, 5'd7, 0, 0, 5'd0, 32'h0, 1, 0);
    chk("starve_cnt_clr", 32'(dut.u_fair.starve_cnt), 32'd0);

    // Continuous contention: LS,LS,LS,IF repeating.
    for (int k = 0; k < 12; k++)
      step(1, 5'(k), 1, 0, 5'(20 + k), 32'(k), (k % 4) == 3, (k % 4) != 3);

    // Alternating fetch and load.
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) step(1, 5'(k), 0, 0, 5'd0, 32'h0, 1, 0);
      else            step(0, 5'd0, 1, 0, 5'(k), 32'h0, 0, 1);
    end

    // Reset right after a fetch grant discards the read.
    @(negedge clk);
    b.if_req = 1'b1; b.if_addr = 5'd4; b.ls_req = 1'b0; b.ls_we = 1'b0;
    #1 chk("rst_pre_gnt", 32'(b.if_gnt), 32'd1);
    @(posedge clk);
    RN = 1'b0;
    #1 chk_zero("rst_mid");
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_no_rvalid", 32'(b.if_rvalid), 32'd0);
    end
    last_addr = '0; last_wd = '0;
    @(negedge clk);
    b.if_req = 1'b0;
    RN = 1'b1;
    step(1, 5'd4, 0, 0, 5'd0, 32'h0, 1, 0);
    step(0, 5'd0, 0, 0, 5'd0, 32'h0, 0, 0);

    chk("if_q_empty", 32'(if_q.size()), 32'd0);
    chk("ls_q_empty", 32'(ls_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/iiitb_mem_arb.md
IIITB_MEM_ARB -- requirements
Module: iiitb_mem_arb

Interface
REQ-001 Parameters: ADDR_W default 5, word address width of the shared 32-entry memory; DATA_W default 32, data width; FAIR_N default 3, maximum consecutive load/store wins over a waiting fetch.
REQ-002 clk input 1: single clock; all state updates on rising edge.
REQ-003 RN input 1: reset, asynchronous, active-low.
REQ-004 if_req input 1: fetch port requests a read; held until granted.
REQ-005 if_addr input ADDR_W: fetch word address.
REQ-006 if_gnt output 1: fetch access issued to memory this cycle (combinational).
REQ-007 if_rvalid output 1: if_rdata valid, one-cycle pulse.
REQ-008 if_rdata output DATA_W: fetch read data.
REQ-009 ls_req, ls_we inputs 1: load/store request; ls_we=1 for store; held until granted.
REQ-010 ls_addr input ADDR_W; ls_wdata input DATA_W: load/store address and store data.
REQ-011 ls_gnt output 1: load/store access issued this cycle (combinational).
REQ-012 ls_rvalid output 1; ls_rdata output DATA_W: load data valid pulse and data.
REQ-013 mem_en, mem_we outputs 1; mem_addr output ADDR_W; mem_wdata output DATA_W: single-port synchronous memory command.
REQ-014 mem_rdata input DATA_W: memory read data, valid the cycle after a read command.
REQ-015 stall_if output 1: high when if_req is high and if_gnt is low.

Function
REQ-016 The block issues at most one memory access per cycle; if_gnt and ls_gnt are never both high.
REQ-017 Default priority: load/store over fetch.
REQ-018 starve_cnt (0..FAIR_N) increments when ls_gnt is high while if_req is high, and clears whenever if_gnt is high.
REQ-019 When starve_cnt equals FAIR_N and both requests are high, fetch is granted instead of load/store.
REQ-020 A single requester is granted in the cycle it asserts, with zero wait.
REQ-021 On a grant: mem_en=1, mem_addr is the winner's address, mem_we=ls_we for load/store and 0 for fetch, and mem_wdata=ls_wdata.
REQ-022 Read-owner FSM states: NONE, IF_RD, LS_RD.
  - Next state is IF_RD after a fetch grant.
  - Next state is LS_RD after a load grant.
  - Next state is NONE after a store grant or an idle cycle.
REQ-023 In IF_RD, if_rvalid=1 and if_rdata=mem_rdata; in LS_RD, ls_rvalid=1 and ls_rdata=mem_rdata; read latency is exactly 1 cycle after grant.
REQ-024 Back-to-back grants are allowed: a new access issues in the same cycle that the previous read data returns.
REQ-025 Stores produce no rvalid and are complete at grant.
REQ-026 When idle, mem_en=0; mem_addr and mem_wdata hold their last value.

Reset
REQ-027 While RN=0, all outputs are 0, the FSM is NONE and starve_cnt is 0, asynchronously.
REQ-028 A read in flight when reset asserts is discarded; no rvalid is produced after reset releases.
REQ-029 Requests are evaluated from the first rising clk edge with RN=1.

Structure
REQ-030 A shared package iiitb_rv32i_pkg holds the FSM state enumeration, ADDR_W/DATA_W defaults and the FAIR_N default.
REQ-031 One sub-module, iiitb_arb_fair, contains the priority/starvation-counter grant logic; the top holds the read-owner FSM and muxing.

Verification
REQ-032 Fetch only: if_req=1 with if_addr=4 and memory word 4 = 0x02328400 -> if_gnt the same cycle; if_rvalid and if_rdata=0x02328400 the next cycle.
REQ-033 Store then load: ls_we=1, addr 3, wdata 0xDEADBEEF, then ls_we=0, addr 3 -> one mem write, then ls_rvalid with 0xDEADBEEF one cycle after the load grant.
REQ-034 Contention with FAIR_N=3: if_req and ls_req held high continuously -> grant pattern LS,LS,LS,IF repeating; stall_if high on the LS cycles.
REQ-035 Both requests in the same cycle with starve_cnt=0 -> ls_gnt=1, if_gnt=0, starve_cnt=1.
REQ-036 RN pulled low in the cycle after a fetch grant -> no if_rvalid; all outputs 0 immediately; the first post-reset fetch returns correct data.
REQ-037 Alternating fetch and load every cycle -> each rvalid routes to the correct port, with no lost or duplicated pulses over 20 cycles.
